// File: rtl/rr_mux_n_way.sv
// rr_mux_n_way: registered N-way W-bit multiplexer with valid/ready handshake on
// every input channel and on the output. Two modes: round-robin arbitration
// (mode=0) or fixed select (mode=1).
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel offer
//   in_ready   per-channel take (at most one bit high, forced low in reset)
//   mode       0 = round-robin, 1 = fixed select
//   fixed_sel  channel index used when mode=1
//   out_data   registered selected word
//   out_sel    index of the channel that supplied out_data
//   out_valid  out_data/out_sel hold a word
//   out_ready  consumer takes the word this cycle
module rr_mux_n_way #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          fixed_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0] CH_MOD  = SEL_W'(CHANNELS);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] best_dist;
    logic [SEL_W-1:0] cur_dist;
    logic             load_ok;
    logic             xfer;

    // Grant selection: fixed index in mode 1, nearest requester at or after ptr in mode 0.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        best_dist  = '0;
        cur_dist   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (mode) begin
                // Only in-range indices can match, so an out-of-range fixed_sel never grants.
                if (in_valid[k] && (fixed_sel == SEL_W'(k))) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SEL_W'(k);
                    grant_data = in_data[k*WIDTH +: WIDTH];
                end
            end else begin
                // Circular distance from ptr; the correction only matters for non-power-of-two CHANNELS.
                cur_dist = SEL_W'(k) - ptr_q;
                if (SEL_W'(k) < ptr_q) begin
                    cur_dist = cur_dist + CH_MOD;
                end
                if (in_valid[k] && (!grant_vld || (cur_dist < best_dist))) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SEL_W'(k);
                    grant_data = in_data[k*WIDTH +: WIDTH];
                    best_dist  = cur_dist;
                end
            end
        end
    end

    // Handshake: output register may load when empty or draining this cycle.
    always_comb begin
        load_ok  = !valid_q || out_ready;
        xfer     = grant_vld && load_ok;
        in_ready = '0;
        if (!reset && xfer) begin
            in_ready = CHANNELS'(1) << grant_idx;
        end
    end

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = grant_data;
            sel_d   = grant_idx;
            valid_d = 1'b1;
            if (!mode) begin
                ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule
